// File: rtl/msrv32_bus_pkg.sv
// Shared constants for the RV32I memory-side responder: region bases,
// timer register offsets and reset values.
package msrv32_bus_pkg;

    localparam logic [15:0] DMEM_BASE_HI_DEF  = 16'h0001;
    localparam logic [15:0] TIMER_BASE_HI_DEF = 16'h0002;

    localparam logic [2:0] MTIME_LO    = 3'd0;
    localparam logic [2:0] MTIME_HI    = 3'd1;
    localparam logic [2:0] MTIMECMP_LO = 3'd2;
    localparam logic [2:0] MTIMECMP_HI = 3'd3;
    localparam logic [2:0] MSIP        = 3'd4;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) result[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/msrv32_mtimer.sv
// Machine timer: prescaled 64-bit mtime, mtimecmp compare, msip, and the
// combinational read mux for the timer register window.
module msrv32_mtimer
    import msrv32_bus_pkg::*;
#(
    parameter int RC_DIV = 1
) (
    input  logic        clk_sys,
    input  logic        rst_b,
    input  logic        wr_en,
    input  logic [2:0]  offset,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_mask,
    output logic [31:0] rdata,
    output logic [63:0] mtime,
    output logic        tirq,
    output logic        sirq
);

    localparam int PW = (RC_DIV > 1) ? $clog2(RC_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [63:0]   mtime_q;
    logic [63:0]   mtimecmp_q;
    logic          msip_q;
    logic          tirq_q;
    logic          tick;
    logic          wr_any;

    assign tick   = (presc_q == PW'(RC_DIV - 1));
    assign wr_any = wr_en && (wr_mask != 4'b0000);

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
            tirq_q     <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            tirq_q  <= (mtime_q >= mtimecmp_q);

            // a software write to mtime wins over the tick in the same cycle
            if (wr_any && offset == MTIME_LO)
                mtime_q[31:0] <= merge_bytes(mtime_q[31:0], wr_data, wr_mask);
            else if (wr_any && offset == MTIME_HI)
                mtime_q[63:32] <= merge_bytes(mtime_q[63:32], wr_data, wr_mask);
            else if (tick)
                mtime_q <= mtime_q + 64'd1;

            if (wr_any && offset == MTIMECMP_LO)
                mtimecmp_q[31:0] <= merge_bytes(mtimecmp_q[31:0], wr_data, wr_mask);
            if (wr_any && offset == MTIMECMP_HI)
                mtimecmp_q[63:32] <= merge_bytes(mtimecmp_q[63:32], wr_data, wr_mask);
            if (wr_en && offset == MSIP && wr_mask[0])
                msip_q <= wr_data[0];
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (offset)
            MTIME_LO:    rdata = mtime_q[31:0];
            MTIME_HI:    rdata = mtime_q[63:32];
            MTIMECMP_LO: rdata = mtimecmp_q[31:0];
            MTIMECMP_HI: rdata = mtimecmp_q[63:32];
            MSIP:        rdata = {31'h0, msip_q};
            default:     rdata = 32'h0;
        endcase
    end

    assign mtime = mtime_q;
    assign tirq  = tirq_q;
    assign sirq  = msip_q;

endmodule

// File: rtl/msrv32_bus_responder.sv
// Memory-side responder for the RV32I core: instruction memory with preload,
// byte-maskable data RAM and the memory-mapped machine timer.
module msrv32_bus_responder
    import msrv32_bus_pkg::*;
#(
    parameter int          IMEM_WORDS    = 1024,
    parameter int          DMEM_WORDS    = 1024,
    parameter logic [15:0] DMEM_BASE_HI  = DMEM_BASE_HI_DEF,
    parameter logic [15:0] TIMER_BASE_HI = TIMER_BASE_HI_DEF,
    parameter int          RC_DIV        = 1
) (
    input  logic                          ms_riscv32_mp_clk_in,
    input  logic                          ms_riscv32_mp_rst_in,
    input  logic [31:0]                   ms_riscv32_mp_imaddr_in,
    output logic [31:0]                   ms_riscv32_mp_instr_out,
    input  logic [31:0]                   ms_riscv32_mp_dmaddr_in,
    input  logic [31:0]                   ms_riscv32_mp_dmdata_in,
    input  logic                          ms_riscv32_mp_dmwr_req_in,
    input  logic [3:0]                    ms_riscv32_mp_dmwr_mask_in,
    output logic [31:0]                   ms_riscv32_mp_dmdata_out,
    output logic [63:0]                   ms_riscv32_mp_rc_out,
    output logic                          ms_riscv32_mp_tirq_out,
    output logic                          ms_riscv32_mp_sirq_out,
    input  logic                          imem_wr_en_in,
    input  logic [$clog2(IMEM_WORDS)-1:0] imem_wr_addr_in,
    input  logic [31:0]                   imem_wr_data_in
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    logic [IAW-1:0] i_idx;
    logic [DAW-1:0] d_idx;
    logic           sel_ram;
    logic           sel_timer;
    logic           ram_wr;
    logic [31:0]    timer_rdata;
    logic [31:0]    load_data;
    logic           unused_addr_bits;

    assign i_idx     = ms_riscv32_mp_imaddr_in[IAW+1:2];
    assign d_idx     = ms_riscv32_mp_dmaddr_in[DAW+1:2];
    assign sel_ram   = (ms_riscv32_mp_dmaddr_in[31:16] == DMEM_BASE_HI);
    assign sel_timer = (ms_riscv32_mp_dmaddr_in[31:16] == TIMER_BASE_HI);
    assign ram_wr    = ms_riscv32_mp_dmwr_req_in && sel_ram;

    // address bits below the word index and above the array depth alias
    assign unused_addr_bits = ^{ms_riscv32_mp_imaddr_in[31:IAW+2],
                                ms_riscv32_mp_imaddr_in[1:0],
                                ms_riscv32_mp_dmaddr_in[15:DAW+2],
                                ms_riscv32_mp_dmaddr_in[1:0]};

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (imem_wr_en_in) imem[imem_wr_addr_in] <= imem_wr_data_in;
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (ms_riscv32_mp_dmwr_mask_in[b])
                    dmem[d_idx][b*8 +: 8] <= ms_riscv32_mp_dmdata_in[b*8 +: 8];
            end
        end
    end

    always_comb begin
        load_data = 32'h0;
        if (sel_ram)
            load_data = dmem[d_idx];
        else if (sel_timer)
            load_data = timer_rdata;
    end

    // both read ports sample the arrays before this edge's writes land
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            ms_riscv32_mp_instr_out  <= NOP_INSTR;
            ms_riscv32_mp_dmdata_out <= 32'h0;
        end else begin
            ms_riscv32_mp_instr_out  <= imem[i_idx];
            ms_riscv32_mp_dmdata_out <= load_data;
        end
    end

    msrv32_mtimer #(
        .RC_DIV (RC_DIV)
    ) u_mtimer (
        .clk_sys (ms_riscv32_mp_clk_in),
        .rst_b   (ms_riscv32_mp_rst_in),
        .wr_en   (ms_riscv32_mp_dmwr_req_in && sel_timer),
        .offset  (ms_riscv32_mp_dmaddr_in[4:2]),
        .wr_data (ms_riscv32_mp_dmdata_in),
        .wr_mask (ms_riscv32_mp_dmwr_mask_in),
        .rdata   (timer_rdata),
        .mtime   (ms_riscv32_mp_rc_out),
        .tirq    (ms_riscv32_mp_tirq_out),
        .sirq    (ms_riscv32_mp_sirq_out)
    );

endmodule

// File: tb/tb_msrv32_bus_responder.sv
// Directed bench for msrv32_bus_responder: one instance with RC_DIV=1 and one
// with RC_DIV=4 driven by the same bus, checked against hand-computed values.
module tb_msrv32_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imaddr;
    logic [31:0] dmaddr;
    logic [31:0] dmdata_in;
    logic        dmwr_req;
    logic [3:0]  dmwr_mask;
    logic        imem_wr_en;
    logic [9:0]  imem_wr_addr;
    logic [31:0] imem_wr_data;

    logic [31:0] instr, dmdata_out;
    logic [63:0] rc;
    logic        tirq, sirq;
    logic [31:0] instr4, dmdata4;
    logic [63:0] rc4;
    logic        tirq4, sirq4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msrv32_bus_responder #(.RC_DIV(1)) u_dut (
        .ms_riscv32_mp_clk_in      (clk),
        .ms_riscv32_mp_rst_in      (rst_n),
        .ms_riscv32_mp_imaddr_in   (imaddr),
        .ms_riscv32_mp_instr_out   (instr),
        .ms_riscv32_mp_dmaddr_in   (dmaddr),
        .ms_riscv32_mp_dmdata_in   (dmdata_in),
        .ms_riscv32_mp_dmwr_req_in (dmwr_req),
        .ms_riscv32_mp_dmwr_mask_in(dmwr_mask),
        .ms_riscv32_mp_dmdata_out  (dmdata_out),
        .ms_riscv32_mp_rc_out      (rc),
        .ms_riscv32_mp_tirq_out    (tirq),
        .ms_riscv32_mp_sirq_out    (sirq),
        .imem_wr_en_in             (imem_wr_en),
        .imem_wr_addr_in           (imem_wr_addr),
        .imem_wr_data_in           (imem_wr_data)
    );

    msrv32_bus_responder #(.RC_DIV(4)) u_dut4 (
        .ms_riscv32_mp_clk_in      (clk),
        .ms_riscv32_mp_rst_in      (rst_n),
        .ms_riscv32_mp_imaddr_in   (imaddr),
        .ms_riscv32_mp_instr_out   (instr4),
        .ms_riscv32_mp_dmaddr_in   (dmaddr),
        .ms_riscv32_mp_dmdata_in   (dmdata_in),
        .ms_riscv32_mp_dmwr_req_in (dmwr_req),
        .ms_riscv32_mp_dmwr_mask_in(dmwr_mask),
        .ms_riscv32_mp_dmdata_out  (dmdata4),
        .ms_riscv32_mp_rc_out      (rc4),
        .ms_riscv32_mp_tirq_out    (tirq4),
        .ms_riscv32_mp_sirq_out    (sirq4),
        .imem_wr_en_in             (imem_wr_en),
        .imem_wr_addr_in           (imem_wr_addr),
        .imem_wr_data_in           (imem_wr_data)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        dmaddr    = a;
        dmdata_in = d;
        dmwr_mask = m;
        dmwr_req  = 1'b1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        drive_store(a, d, m);
        cyc();
        dmwr_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imaddr = 32'h0; dmaddr = 32'h0; dmdata_in = 32'h0;
        dmwr_req = 1'b0; dmwr_mask = 4'h0;
        imem_wr_en = 1'b1; imem_wr_addr = 10'd0; imem_wr_data = 32'h00A0_0093;
        cyc();
        imem_wr_en = 1'b0;
        cyc();
        checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %h exp %h", instr, 32'h13); end
        checks++; if (dmdata_out !== 32'h0) begin errors++; $display("FAIL reset_dmdata got %h exp 0", dmdata_out); end
        checks++; if (rc !== 64'h0 || rc4 !== 64'h0) begin errors++; $display("FAIL reset_rc got %h/%h exp 0", rc, rc4); end
        checks++; if ({tirq, sirq} !== 2'b00) begin errors++; $display("FAIL reset_irq got %b exp 00", {tirq, sirq}); end
        rst_n = 1'b1;
        cyc();
        checks++; if (instr !== 32'h00A0_0093) begin errors++; $display("FAIL fetch_after_reset got %h exp %h", instr, 32'h00A00093); end
        checks++; if (rc !== 64'd1) begin errors++; $display("FAIL first_tick got %h exp 1", rc); end
    endtask

    task automatic test_imem();
        imaddr = 32'h0000_1000;
        cyc();
        checks++; if (instr !== 32'h00A0_0093) begin errors++; $display("FAIL imem_alias got %h exp %h", instr, 32'h00A00093); end
        imem_wr_en = 1'b1; imem_wr_addr = 10'd1; imem_wr_data = 32'h1111_1111;
        cyc();
        imem_wr_data = 32'h2222_2222; imaddr = 32'h0000_0004;
        cyc();
        checks++; if (instr !== 32'h1111_1111) begin errors++; $display("FAIL imem_rbw_old got %h exp %h", instr, 32'h11111111); end
        imem_wr_en = 1'b0;
        cyc();
        checks++; if (instr !== 32'h2222_2222) begin errors++; $display("FAIL imem_rbw_new got %h exp %h", instr, 32'h22222222); end
    endtask

    task automatic test_byte_store();
        store(32'h0001_0008, 32'hDEAD_BEEF, 4'b1111);
        store(32'h0001_0008, 32'h0000_0055, 4'b0001);
        cyc();
        checks++; if (dmdata_out !== 32'hDEAD_BE55) begin errors++; $display("FAIL byte_mask got %h exp %h", dmdata_out, 32'hDEADBE55); end
        store(32'h0001_0008, 32'hFFFF_FFFF, 4'b0000);
        cyc();
        checks++; if (dmdata_out !== 32'hDEAD_BE55) begin errors++; $display("FAIL mask_zero got %h exp %h", dmdata_out, 32'hDEADBE55); end
        store(32'h0001_0008, 32'hAABB_CCDD, 4'b1010);
        dmaddr = 32'h0001_000B;
        cyc();
        checks++; if (dmdata_out !== 32'hAAAD_CC55) begin errors++; $display("FAIL mask_1010 got %h exp %h", dmdata_out, 32'hAAADCC55); end
    endtask

    task automatic test_rbw();
        store(32'h0001_0010, 32'h0, 4'b1111);
        cyc();
        drive_store(32'h0001_0010, 32'h1234_5678, 4'b1111);
        cyc();
        checks++; if (dmdata_out !== 32'h0) begin errors++; $display("FAIL rbw_old got %h exp 0", dmdata_out); end
        dmwr_req = 1'b0;
        cyc();
        checks++; if (dmdata_out !== 32'h1234_5678) begin errors++; $display("FAIL rbw_new got %h exp %h", dmdata_out, 32'h12345678); end
    endtask

    task automatic test_timer_carry();
        store(32'h0002_0000, 32'hFFFF_FFFF, 4'b1111);
        store(32'h0002_0004, 32'h0, 4'b1111);
        checks++; if (rc !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL mtime_written got %h exp %h", rc, 64'hFFFFFFFF); end
        cyc();
        checks++; if (rc !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL mtime_carry got %h exp %h", rc, 64'h100000000); end
        drive_store(32'h0002_0000, 32'h0000_0100, 4'b1111);
        cyc(); cyc(); cyc();
        checks++; if (rc !== 64'h0000_0001_0000_0100) begin errors++; $display("FAIL write_priority got %h exp %h", rc, 64'h100000100); end
        dmwr_req = 1'b0;
        dmaddr = 32'h0002_0004;
        cyc();
        checks++; if (rc !== 64'h0000_0001_0000_0101) begin errors++; $display("FAIL tick_resume got %h exp %h", rc, 64'h100000101); end
        checks++; if (dmdata_out !== 32'h1) begin errors++; $display("FAIL mtime_hi_load got %h exp 1", dmdata_out); end
    endtask

    task automatic test_timer_irq();
        int n;
        logic early;
        store(32'h0002_0000, 32'h0, 4'b1111);
        store(32'h0002_0004, 32'h0, 4'b1111);
        store(32'h0002_0008, 32'd20, 4'b1111);
        store(32'h0002_000C, 32'h0, 4'b1111);
        n = 0; early = 1'b0;
        while (rc4 !== 64'd20 && n < 200) begin
            if (tirq4 !== 1'b0) early = 1'b1;
            cyc();
            n++;
        end
        checks++; if (n >= 200) begin errors++; $display("FAIL mtime_reach_20 got %h exp %h", rc4, 64'd20); end
        checks++; if (early !== 1'b0 || tirq4 !== 1'b0) begin errors++; $display("FAIL tirq_early got %b exp 0", tirq4); end
        cyc();
        checks++; if (tirq4 !== 1'b1) begin errors++; $display("FAIL tirq_rise got %b exp 1", tirq4); end
        checks++; if (tirq !== 1'b1) begin errors++; $display("FAIL tirq_div1 got %b exp 1", tirq); end
        store(32'h0002_0008, 32'd1000, 4'b1111);
        checks++; if (tirq4 !== 1'b1) begin errors++; $display("FAIL tirq_hold got %b exp 1", tirq4); end
        cyc();
        checks++; if (tirq4 !== 1'b0 || tirq !== 1'b0) begin errors++; $display("FAIL tirq_drop got %b/%b exp 0/0", tirq4, tirq); end
    endtask

    task automatic test_sirq_unmapped();
        checks++; if (sirq !== 1'b0) begin errors++; $display("FAIL sirq_idle got %b exp 0", sirq); end
        store(32'h0002_0010, 32'h1, 4'b0001);
        checks++; if (sirq !== 1'b1 || sirq4 !== 1'b1) begin errors++; $display("FAIL sirq_set got %b exp 1", sirq); end
        cyc();
        checks++; if (dmdata_out !== 32'h1) begin errors++; $display("FAIL msip_load got %h exp 1", dmdata_out); end
        store(32'h0002_0010, 32'h0, 4'b0000);
        checks++; if (sirq !== 1'b1) begin errors++; $display("FAIL sirq_mask0 got %b exp 1", sirq); end
        store(32'h0002_0010, 32'h0, 4'b0001);
        checks++; if (sirq !== 1'b0) begin errors++; $display("FAIL sirq_clear got %b exp 0", sirq); end
        dmaddr = 32'h0002_0014;
        cyc();
        checks++; if (dmdata_out !== 32'h0) begin errors++; $display("FAIL timer_off5 got %h exp 0", dmdata_out); end
        store(32'h0001_0000, 32'hCAFE_F00D, 4'b1111);
        store(32'h0005_0000, 32'hFFFF_FFFF, 4'b1111);
        cyc();
        checks++; if (dmdata_out !== 32'h0) begin errors++; $display("FAIL unmapped_load got %h exp 0", dmdata_out); end
        dmaddr = 32'h0001_0000;
        cyc();
        checks++; if (dmdata_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL unmapped_nowrite got %h exp %h", dmdata_out, 32'hCAFEF00D); end
    endtask

    task automatic test_reset_mid();
        store(32'h0002_0010, 32'h1, 4'b0001);
        dmaddr = 32'h0001_0008;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rc !== 64'h0 || sirq !== 1'b0 || dmdata_out !== 32'h0 || instr !== 32'h13) begin
            errors++; $display("FAIL async_reset got rc=%h sirq=%b d=%h i=%h exp 0/0/0/13", rc, sirq, dmdata_out, instr);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++; if (dmdata_out !== 32'hAAAD_CC55) begin errors++; $display("FAIL ram_survives got %h exp %h", dmdata_out, 32'hAAADCC55); end
        dmaddr = 32'h0002_000C;
        cyc();
        checks++; if (dmdata_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mtimecmp_reset got %h exp %h", dmdata_out, 32'hFFFFFFFF); end
    endtask

    initial begin
        test_reset();
        test_imem();
        test_byte_store();
        test_rbw();
        test_timer_carry();
        test_timer_irq();
        test_sirq_unmapped();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
